// File: rtl/fft_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : fft_frame_scheduler
// Description : Frame sequencer for the spectral pipeline. Loads FRAME_LEN
//               codec samples into the FFT input buffer, starts the
//               transform, commands the bin unload toward main_fsm and holds
//               the next frame until main_fsm reports note_done. Samples that
//               arrive while no frame is being filled are dropped and counted.
// Optional    : FFT_SCHED_NOTE_TIMEOUT_EN - watchdog on WAIT_NOTE; after
//               NOTE_TIMEOUT cycles without note_done the frame is abandoned
//               and the sticky timeout flag is set. Undefined: wait forever,
//               timeout tied to 0.
// Ports       : clk, rst_n (async, active low)
//               enable, clear_status            - control / status clear
//               sample_ready, sample_in         - codec sample strobe + data
//               fft_load_valid/addr/data        - FFT input buffer write
//               fft_start, fft_done             - transform handshake
//               fft_unload, fft_read_valid      - bin stream handshake
//               note_done                       - main_fsm analysis complete
//               busy, frame_count, overrun,
//               drop_count, timeout             - status
// Revision    : 1.0 - initial release
// ============================================================================
module fft_frame_scheduler #(
  parameter int FRAME_LEN    = 512,
  parameter int ADDR_W       = 9,
  parameter int SAMPLE_W     = 18,
  parameter int NOTE_TIMEOUT = 65535
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                clear_status,
  input  logic                sample_ready,
  input  logic [SAMPLE_W-1:0] sample_in,
  output logic                fft_load_valid,
  output logic [ADDR_W-1:0]   fft_load_addr,
  output logic [SAMPLE_W-1:0] fft_load_data,
  output logic                fft_start,
  input  logic                fft_done,
  output logic                fft_unload,
  input  logic                fft_read_valid,
  input  logic                note_done,
  output logic                busy,
  output logic [15:0]         frame_count,
  output logic                overrun,
  output logic [7:0]          drop_count,
  output logic                timeout
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FILL      = 3'd1,
    START     = 3'd2,
    WAIT_FFT  = 3'd3,
    UNLOAD    = 3'd4,
    WAIT_NOTE = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(FRAME_LEN - 1);
  localparam logic [15:0]       TIMER_LAST = 16'(NOTE_TIMEOUT - 1);

  state_t              state, state_d;
  logic [ADDR_W-1:0]   sample_cnt, sample_cnt_d;
  logic [ADDR_W-1:0]   bin_cnt, bin_cnt_d;
  logic [15:0]         timer, timer_d;
  logic                load_valid_d;
  logic [ADDR_W-1:0]   load_addr_d;
  logic [SAMPLE_W-1:0] load_data_d;
  logic                start_d;
  logic                unload_d;
  logic [15:0]         frame_count_d;
  logic                busy_d;
  logic                drop;
`ifdef FFT_SCHED_NOTE_TIMEOUT_EN
  logic                timeout_set;
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and next-output logic; every output is registered below.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state;
    sample_cnt_d  = sample_cnt;
    bin_cnt_d     = bin_cnt;
    timer_d       = timer;
    load_valid_d  = 1'b0;
    load_addr_d   = fft_load_addr;
    load_data_d   = fft_load_data;
    start_d       = 1'b0;
    unload_d      = 1'b0;
    frame_count_d = frame_count;
    // Only FILL consumes samples; anything else arriving is lost.
    drop          = sample_ready && (state != FILL);
`ifdef FFT_SCHED_NOTE_TIMEOUT_EN
    timeout_set   = 1'b0;
`endif

    case (state)
      IDLE: begin
        if (enable) begin
          state_d      = FILL;
          sample_cnt_d = '0;
        end
      end

      FILL: begin
        // Dropping enable discards the partial frame, including a sample
        // strobed in the same cycle.
        if (!enable) begin
          state_d      = IDLE;
          sample_cnt_d = '0;
        end else if (sample_ready) begin
          load_valid_d = 1'b1;
          load_addr_d  = sample_cnt;
          load_data_d  = sample_in;
          sample_cnt_d = sample_cnt + ADDR_W'(1);
          if (sample_cnt == LAST_IDX) begin
            state_d = START;
          end
        end
      end

      // The start pulse follows the final buffer write by one cycle so the
      // core never starts before its last input lands.
      START: begin
        start_d = 1'b1;
        state_d = WAIT_FFT;
      end

      WAIT_FFT: begin
        if (fft_done) begin
          state_d   = UNLOAD;
          unload_d  = 1'b1;
          bin_cnt_d = '0;
        end
      end

      UNLOAD: begin
        if (fft_read_valid) begin
          bin_cnt_d = bin_cnt + ADDR_W'(1);
          if (bin_cnt == LAST_IDX) begin
            state_d = WAIT_NOTE;
            timer_d = '0;
          end
        end
      end

      WAIT_NOTE: begin
        if (note_done) begin
          frame_count_d = frame_count + 16'd1;
          state_d       = enable ? FILL : IDLE;
          sample_cnt_d  = '0;
        end else if (timer == TIMER_LAST) begin
          // The timer parks at its limit; only the watchdog build acts on it.
`ifdef FFT_SCHED_NOTE_TIMEOUT_EN
          timeout_set  = 1'b1;
          state_d      = enable ? FILL : IDLE;
          sample_cnt_d = '0;
`endif
        end else begin
          timer_d = timer + 16'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // --------------------------------------------------------------------------
  // Counters and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt     <= '0;
      bin_cnt        <= '0;
      timer          <= '0;
      fft_load_valid <= 1'b0;
      fft_load_addr  <= '0;
      fft_load_data  <= '0;
      fft_start      <= 1'b0;
      fft_unload     <= 1'b0;
      frame_count    <= '0;
      busy           <= 1'b0;
    end else begin
      sample_cnt     <= sample_cnt_d;
      bin_cnt        <= bin_cnt_d;
      timer          <= timer_d;
      fft_load_valid <= load_valid_d;
      fft_load_addr  <= load_addr_d;
      fft_load_data  <= load_data_d;
      fft_start      <= start_d;
      fft_unload     <= unload_d;
      frame_count    <= frame_count_d;
      busy           <= busy_d;
    end
  end

  // --------------------------------------------------------------------------
  // Sticky status. A clear wins over a simultaneous event, so a sample dropped
  // in the clear cycle is not counted.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun    <= 1'b0;
      drop_count <= '0;
    end else if (clear_status) begin
      overrun    <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overrun <= 1'b1;
      if (drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

`ifdef FFT_SCHED_NOTE_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout <= 1'b0;
    end else if (clear_status) begin
      timeout <= 1'b0;
    end else if (timeout_set) begin
      timeout <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule
`default_nettype wire
